oam_dma_ctrl: RTL and testbench
===============================

// Module: oam_dma_ctrl
// PURPOSE
//  Bus initiator for the PPU register interface: the NES $4014 sprite DMA engine.
//  Snoops CPU writes; on a write to $4014 it halts the CPU and copies XFER_LEN bytes
//  from CPU page $XX00 into PPU OAMDATA ($2004), one register-interface write per byte.
//  Sits beside the CPU in nes_top; top level muxes CPU/DMA buses on dma_active_out.
// PARAMETERS
//  DMA_REG_ADDR  16'h4014  CPU address that triggers DMA
//  OAM_DATA_SEL  3'd4      ri_sel value of OAMDATA
//  XFER_LEN      256       bytes per transfer, 1..256
// PORTS
//  clk             in   1   pixel clock, all logic on rising edge
//  rst             in   1   asynchronous, active-high reset
//  cpu_ce_in       in   1   one-clk pulse marking a CPU bus cycle; all state advances only on it
//  cpu_addr_in     in   16  CPU address (snooped)
//  cpu_r_nw_in     in   1   CPU read(1)/write(0)
//  cpu_d_in        in   8   CPU write data (page number)
//  cpu_rdy_out     out  1   0 = CPU halted
//  dma_active_out  out  1   1 = DMA owns memory bus and PPU register interface
//  mem_addr_out    out  16  DMA read address {page, index}
//  mem_rd_out      out  1   DMA read strobe
//  mem_d_in        in   8   read data, valid on the READ-state cpu_ce_in cycle
//  ri_sel_out      out  3   PPU register select
//  ri_cs_out       out  1   PPU register chip select, one-clk pulse per byte
//  ri_r_nw_out     out  1   PPU read(1)/write(0)
//  ri_d_out        out  8   PPU write data
// BEHAVIOUR
//  Reset: state IDLE, parity=0, index=0, page=0, buffer=0; cpu_rdy_out=1, dma_active_out=0,
//   mem_addr_out=0, mem_rd_out=0, ri_sel_out=0, ri_cs_out=0, ri_r_nw_out=1, ri_d_out=0.
//  parity: toggles on every cpu_ce_in, in every state (models CPU get/put cycle).
//  Trigger: IDLE & cpu_ce_in & !cpu_r_nw_in & cpu_addr_in==DMA_REG_ADDR -> page<=cpu_d_in,
//   index<=0, state HALT. Reads of DMA_REG_ADDR and writes elsewhere: no effect.
//  States (transitions on cpu_ce_in only):
//   IDLE  -> HALT on trigger
//   HALT  -> ALIGN if parity==1 at this ce, else READ
//   ALIGN -> READ (dummy cycle)
//   READ  : mem_rd_out=1, mem_addr_out={page,index}; buffer<=mem_d_in on ce -> WRITE
//   WRITE : on ce, register ri_sel_out<=OAM_DATA_SEL, ri_r_nw_out<=0, ri_d_out<=buffer,
//           ri_cs_out<=1 for exactly the next clk; index<=index+1;
//           -> IDLE if index==XFER_LEN-1, else READ
//  Total halt = 1+512 ce cycles (parity 0 at HALT) or 1+1+512 (parity 1), for XFER_LEN=256.
//  cpu_rdy_out=0 and dma_active_out=1 from the clk after trigger ce until the clk after the
//   last WRITE ce; both registered, both change in the same clk.
//  ri_cs_out is 0 in all other clks; ri_sel_out/ri_d_out hold last value, ri_r_nw_out
//   returns to 1 when ri_cs_out drops. mem_rd_out/mem_addr_out valid only in READ, else 0.
//  Index: 8-bit, no wrap beyond page; page boundary never crossed.
//  Trigger writes while not IDLE: ignored (page unchanged).
//  cpu_ce_in gaps of any length: state, outputs held; no duplicate ri_cs_out pulses.
//  rst mid-transfer: immediate return to reset values; partial transfer abandoned;
//   next trigger restarts at index 0.
// TESTING
//  1 parity=0, write $02 to $4014 -> 513 ce cycles rdy low, mem_addr $0200..$02FF in order,
//    256 ri_cs pulses, sel=4, r_nw=0, data==mem pattern (addr[7:0]^8'h5A).
//  2 same trigger with parity=1 -> 514 ce cycles rdy low, one ALIGN cycle before first READ.
//  3 read of $4014, write to $4015 and $2014 -> cpu_rdy stays 1, no ri_cs/mem_rd activity.
//  4 rst asserted after byte 100 -> outputs at reset values same clk; retrigger page $03
//    -> 256 fresh writes starting at $0300.
//  5 cpu_ce every 3 clks, then every 12 clks with random gaps -> identical byte sequence,
//    exactly one 1-clk ri_cs pulse per byte.
//  6 write $07 to $4014 during active DMA from page $02 -> ignored, all reads stay in $02xx.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA engine ($4014): halts the CPU and streams one CPU page into PPU OAMDATA,
// one register-interface write per byte, all state advancing on cpu_ce_in.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [2:0]  OAM_DATA_SEL = 3'd4,
    parameter int          XFER_LEN     = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce_in,
    input  logic [15:0] cpu_addr_in,
    input  logic        cpu_r_nw_in,
    input  logic [7:0]  cpu_d_in,
    output logic        cpu_rdy_out,
    output logic        dma_active_out,
    output logic [15:0] mem_addr_out,
    output logic        mem_rd_out,
    input  logic [7:0]  mem_d_in,
    output logic [2:0]  ri_sel_out,
    output logic        ri_cs_out,
    output logic        ri_r_nw_out,
    output logic [7:0]  ri_d_out
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t     state;
    logic       parity;
    logic [7:0] index;
    logic [7:0] page;
    logic [7:0] buffer;
    logic       trigger;

    assign trigger = !cpu_r_nw_in && (cpu_addr_in == DMA_REG_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            parity         <= 1'b0;
            index          <= 8'd0;
            page           <= 8'd0;
            buffer         <= 8'd0;
            cpu_rdy_out    <= 1'b1;
            dma_active_out <= 1'b0;
            mem_addr_out   <= 16'd0;
            mem_rd_out     <= 1'b0;
            ri_sel_out     <= 3'd0;
            ri_cs_out      <= 1'b0;
            ri_r_nw_out    <= 1'b1;
            ri_d_out       <= 8'd0;
        end else begin
            // The chip-select pulse lasts one clk regardless of how sparse cpu_ce_in is.
            ri_cs_out   <= 1'b0;
            ri_r_nw_out <= 1'b1;
            if (cpu_ce_in) begin
                parity <= ~parity;
                case (state)
                    IDLE: begin
                        if (trigger) begin
                            page           <= cpu_d_in;
                            index          <= 8'd0;
                            state          <= HALT;
                            cpu_rdy_out    <= 1'b0;
                            dma_active_out <= 1'b1;
                        end
                    end
                    HALT: begin
                        if (parity) begin
                            state <= ALIGN;
                        end else begin
                            state        <= READ;
                            mem_rd_out   <= 1'b1;
                            mem_addr_out <= {page, index};
                        end
                    end
                    ALIGN: begin
                        state        <= READ;
                        mem_rd_out   <= 1'b1;
                        mem_addr_out <= {page, index};
                    end
                    READ: begin
                        buffer       <= mem_d_in;
                        mem_rd_out   <= 1'b0;
                        mem_addr_out <= 16'd0;
                        state        <= WRITE;
                    end
                    WRITE: begin
                        ri_sel_out  <= OAM_DATA_SEL;
                        ri_r_nw_out <= 1'b0;
                        ri_d_out    <= buffer;
                        ri_cs_out   <= 1'b1;
                        index       <= index + 8'd1;
                        if (index == LAST_IDX) begin
                            state          <= IDLE;
                            cpu_rdy_out    <= 1'b1;
                            dma_active_out <= 1'b0;
                        end else begin
                            state        <= READ;
                            mem_rd_out   <= 1'b1;
                            mem_addr_out <= {page, index + 8'd1};
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl: a transfer-level model predicts every output each clk.
module tb_oam_dma_ctrl;

    localparam int XFER = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_ce_in = 1'b0;
    logic [15:0] cpu_addr_in = 16'd0;
    logic        cpu_r_nw_in = 1'b1;
    logic [7:0]  cpu_d_in = 8'd0;
    logic        cpu_rdy_out;
    logic        dma_active_out;
    logic [15:0] mem_addr_out;
    logic        mem_rd_out;
    logic [7:0]  mem_d_in;
    logic [2:0]  ri_sel_out;
    logic        ri_cs_out;
    logic        ri_r_nw_out;
    logic [7:0]  ri_d_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory contents: low address byte xor 0x5A.
    assign mem_d_in = mem_addr_out[7:0] ^ 8'h5A;

    oam_dma_ctrl #(
        .DMA_REG_ADDR(16'h4014),
        .OAM_DATA_SEL(3'd4),
        .XFER_LEN(XFER)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu_ce_in(cpu_ce_in),
        .cpu_addr_in(cpu_addr_in),
        .cpu_r_nw_in(cpu_r_nw_in),
        .cpu_d_in(cpu_d_in),
        .cpu_rdy_out(cpu_rdy_out),
        .dma_active_out(dma_active_out),
        .mem_addr_out(mem_addr_out),
        .mem_rd_out(mem_rd_out),
        .mem_d_in(mem_d_in),
        .ri_sel_out(ri_sel_out),
        .ri_cs_out(ri_cs_out),
        .ri_r_nw_out(ri_r_nw_out),
        .ri_d_out(ri_d_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 20) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: a transfer is a count of ce cycles; position within it decides the phase.
    logic       m_par, m_align, m_cs, m_wrote;
    logic [7:0] m_page, m_wd;
    int         m_rem, m_tot;

    // Byte number k if position pos is the read (want_write=0) or write phase of byte k, else -1.
    function automatic int phase_byte(input int pos, input logic al, input logic want_write);
        int p;
        p = pos - 1 - (al ? 1 : 0);
        if (p < 0) return -1;
        if ((p % 2) == (want_write ? 1 : 0)) return p / 2;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_par <= 1'b0; m_align <= 1'b0; m_cs <= 1'b0; m_wrote <= 1'b0;
            m_page <= 8'd0; m_wd <= 8'd0; m_rem <= 0; m_tot <= 0;
        end else begin
            m_cs <= 1'b0;
            if (cpu_ce_in) begin
                m_par <= ~m_par;
                if (m_rem == 0) begin
                    if (!cpu_r_nw_in && cpu_addr_in == 16'h4014) begin
                        m_page  <= cpu_d_in;
                        m_align <= ~m_par;
                        m_tot   <= 1 + (m_par ? 0 : 1) + 2 * XFER;
                        m_rem   <= 1 + (m_par ? 0 : 1) + 2 * XFER;
                    end
                end else begin
                    m_rem <= m_rem - 1;
                    if (phase_byte(m_tot - m_rem, m_align, 1'b1) >= 0) begin
                        m_cs    <= 1'b1;
                        m_wrote <= 1'b1;
                        m_wd    <= 8'(phase_byte(m_tot - m_rem, m_align, 1'b1)) ^ 8'h5A;
                    end
                end
            end
        end
    end

    int          exp_k;
    logic [15:0] exp_addr;
    always @(negedge clk) begin
        if (!rst) begin
            exp_k    = (m_rem > 0) ? phase_byte(m_tot - m_rem, m_align, 1'b0) : -1;
            exp_addr = (exp_k >= 0) ? {m_page, 8'(exp_k)} : 16'd0;
            chk("cpu_rdy", 32'(cpu_rdy_out), 32'(m_rem == 0));
            chk("dma_active", 32'(dma_active_out), 32'(m_rem != 0));
            chk("mem_rd", 32'(mem_rd_out), 32'(exp_k >= 0));
            chk("mem_addr", 32'(mem_addr_out), 32'(exp_addr));
            chk("ri_cs", 32'(ri_cs_out), 32'(m_cs));
            chk("ri_r_nw", 32'(ri_r_nw_out), 32'(!m_cs));
            chk("ri_sel", 32'(ri_sel_out), m_wrote ? 32'd4 : 32'd0);
            chk("ri_d", 32'(ri_d_out), 32'(m_wd));
        end
    end

    // Per-transfer statistics gathered by the stimulus process itself.
    int          halt_ces, cs_cnt;
    logic        got_first;
    logic [15:0] first_addr, last_addr;

    task automatic clear_stats();
        halt_ces = 0; cs_cnt = 0; got_first = 1'b0; first_addr = 16'd0; last_addr = 16'd0;
    endtask

    task automatic step();
        @(negedge clk);
        if (ri_cs_out) cs_cnt++;
        if (mem_rd_out) begin
            if (!got_first) first_addr = mem_addr_out;
            got_first = 1'b1;
            last_addr = mem_addr_out;
        end
    endtask

    task automatic ce_cycle(input int gap, input logic [15:0] a, input logic rnw, input logic [7:0] d);
        for (int i = 1; i < gap; i++) begin
            cpu_ce_in = 1'b0;
            step();
        end
        cpu_addr_in = a; cpu_r_nw_in = rnw; cpu_d_in = d; cpu_ce_in = 1'b1;
        if (!cpu_rdy_out) halt_ces++;
        step();
        cpu_ce_in = 1'b0;
    endtask

    // Random CPU bus cycle that is never a write to $4014.
    task automatic rand_op(input int gap_lo, input int gap_hi);
        logic [15:0] a;
        logic        rnw;
        a   = 16'($urandom);
        rnw = 1'($urandom);
        case ($urandom_range(0, 3))
            0: a = 16'h4015;
            1: a = 16'h2014;
            3: begin a = 16'h4014; rnw = 1'b1; end
            default: ;
        endcase
        if (a == 16'h4014) rnw = 1'b1;
        ce_cycle($urandom_range(gap_lo, gap_hi), a, rnw, 8'($urandom));
    endtask

    // Make the next ce carry the wanted parity (model parity before that ce).
    task automatic set_parity(input logic p);
        if (m_par != p) ce_cycle(1, 16'h0000, 1'b1, 8'h00);
    endtask

    task automatic run_dma(input int gap_lo, input int gap_hi);
        int n;
        n = 0;
        while (cpu_rdy_out == 1'b0 && n < 4000) begin
            rand_op(gap_lo, gap_hi);
            n++;
        end
        if (n >= 4000) begin
            checks++; errors++;
            $display("FAIL dma_timeout actual=%0d required=<4000 ce cycles", n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy"}, 32'(cpu_rdy_out), 32'd1);
        chk({tag, "_active"}, 32'(dma_active_out), 32'd0);
        chk({tag, "_mem_rd"}, 32'(mem_rd_out), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr_out), 32'd0);
        chk({tag, "_ri_cs"}, 32'(ri_cs_out), 32'd0);
        chk({tag, "_ri_r_nw"}, 32'(ri_r_nw_out), 32'd1);
        chk({tag, "_ri_sel"}, 32'(ri_sel_out), 32'd0);
        chk({tag, "_ri_d"}, 32'(ri_d_out), 32'd0);
    endtask

    initial begin
        clear_stats();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Parity 0 at HALT: 513 halted ce cycles, page $02.
        clear_stats();
        set_parity(1'b1);
        ce_cycle(1, 16'h4014, 1'b0, 8'h02);
        run_dma(1, 1);
        chk("t1_halt_ces", 32'(halt_ces), 32'd513);
        chk("t1_pulses", 32'(cs_cnt), 32'd256);
        chk("t1_first_addr", 32'(first_addr), 32'h0200);
        chk("t1_last_addr", 32'(last_addr), 32'h02FF);
        chk("t1_last_data", 32'(ri_d_out), 32'h00A5);

        // Parity 1 at HALT: one extra ALIGN cycle.
        clear_stats();
        set_parity(1'b0);
        ce_cycle(1, 16'h4014, 1'b0, 8'h02);
        run_dma(1, 2);
        chk("t2_halt_ces", 32'(halt_ces), 32'd514);
        chk("t2_pulses", 32'(cs_cnt), 32'd256);

        // Near-miss accesses never start a transfer.
        clear_stats();
        ce_cycle(1, 16'h4014, 1'b1, 8'h02);
        ce_cycle(2, 16'h4015, 1'b0, 8'h02);
        ce_cycle(1, 16'h2014, 1'b0, 8'h02);
        for (int i = 0; i < 20; i++) rand_op(1, 3);
        chk("t3_halt_ces", 32'(halt_ces), 32'd0);
        chk("t3_pulses", 32'(cs_cnt), 32'd0);
        chk("t3_mem_rd_seen", 32'(got_first), 32'd0);

        // Reset after byte 100, then a fresh transfer from page $03.
        clear_stats();
        ce_cycle(1, 16'h4014, 1'b0, 8'h02);
        for (int n = 0; n < 1000 && cs_cnt < 100; n++) rand_op(1, 2);
        chk("t4_pulses_before_rst", 32'(cs_cnt), 32'd100);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        clear_stats();
        ce_cycle(1, 16'h4014, 1'b0, 8'h03);
        run_dma(1, 1);
        chk("t4_pulses", 32'(cs_cnt), 32'd256);
        chk("t4_first_addr", 32'(first_addr), 32'h0300);
        chk("t4_last_addr", 32'(last_addr), 32'h03FF);

        // Sparse ce: every 3 clks, then random gaps up to 12 clks.
        clear_stats();
        set_parity(1'b1);
        ce_cycle(3, 16'h4014, 1'b0, 8'h02);
        run_dma(3, 3);
        chk("t5a_halt_ces", 32'(halt_ces), 32'd513);
        chk("t5a_pulses", 32'(cs_cnt), 32'd256);
        clear_stats();
        set_parity(1'b0);
        ce_cycle(12, 16'h4014, 1'b0, 8'h02);
        run_dma(1, 12);
        chk("t5b_halt_ces", 32'(halt_ces), 32'd514);
        chk("t5b_pulses", 32'(cs_cnt), 32'd256);
        chk("t5b_last_addr", 32'(last_addr), 32'h02FF);

        // Retrigger during an active transfer is ignored.
        clear_stats();
        ce_cycle(1, 16'h4014, 1'b0, 8'h02);
        for (int i = 0; i < 10; i++) rand_op(1, 2);
        ce_cycle(1, 16'h4014, 1'b0, 8'h07);
        for (int i = 0; i < 10; i++) rand_op(1, 2);
        ce_cycle(1, 16'h4014, 1'b0, 8'h07);
        run_dma(1, 2);
        chk("t6_pulses", 32'(cs_cnt), 32'd256);
        chk("t6_first_addr", 32'(first_addr), 32'h0200);
        chk("t6_last_addr", 32'(last_addr), 32'h02FF);
        for (int i = 0; i < 5; i++) rand_op(1, 2);
        chk("t6_idle_rdy", 32'(cpu_rdy_out), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
